// File: rtl/sm_debug_ctrl.sv
// Run/halt/single-step controller and register-file dump sequencer for the sm_top CPU.
// Latency: commands act at the accepting edge; each dump beat costs SETTLE+1 cycles with dump_ready=1.
// Backpressure: a beat is held stable until dump_ready; cmd_ready is low while stepping or scanning.
module sm_debug_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int REG_FIRST    = 0,
    parameter int REG_LAST     = 31,
    parameter int STEP_CYCLES  = 1,
    parameter int SETTLE       = 1,
    parameter int RUN_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    output logic              cpuEnable,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              halted,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [2:0] {
        S_RUN,
        S_HALT,
        S_STEP,
        S_SCAN_WAIT,
        S_SCAN_OUT
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;

    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(REG_FIRST);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(REG_LAST);
    localparam logic [31:0]       STEP_N   = 32'(STEP_CYCLES);
    localparam logic [31:0]       SETTLE_N = 32'(SETTLE);

    state_t      state;
    // Shared down-counter: step cycles in STEP, settle cycles in SCAN_WAIT.
    logic [31:0] cnt;

    logic cmd_fire;
    logic beat_fire;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_fire = dump_valid & dump_ready;

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= (RUN_ON_RESET != 0) ? S_RUN : S_HALT;
            cpuEnable  <= (RUN_ON_RESET != 0);
            halted     <= (RUN_ON_RESET == 0);
            cmd_ready  <= 1'b1;
            cnt        <= '0;
            regAddr    <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            // Counts cycles in which the core clock was enabled; wraps naturally.
            if (cpuEnable) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            case (state)
                S_RUN, S_HALT: begin
                    if (cmd_fire) begin
                        if (cmd_op == OP_RUN) begin
                            state     <= S_RUN;
                            cpuEnable <= 1'b1;
                            halted    <= 1'b0;
                        end else if (cmd_op == OP_HALT ||
                                     (cmd_op == OP_STEP && state == S_RUN)) begin
                            // A step while running just stops the core.
                            state     <= S_HALT;
                            cpuEnable <= 1'b0;
                            halted    <= 1'b1;
                        end else if (cmd_op == OP_STEP) begin
                            state     <= S_STEP;
                            cpuEnable <= 1'b1;
                            halted    <= 1'b0;
                            cmd_ready <= 1'b0;
                            cnt       <= STEP_N;
                        end else begin
                            // Dump: freeze the core and start addressing the first register.
                            state     <= S_SCAN_WAIT;
                            cpuEnable <= 1'b0;
                            halted    <= 1'b0;
                            cmd_ready <= 1'b0;
                            regAddr   <= FIRST_A;
                            cnt       <= SETTLE_N;
                        end
                    end
                end

                S_STEP: begin
                    if (cnt == 32'd1) begin
                        state     <= S_HALT;
                        cpuEnable <= 1'b0;
                        halted    <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end

                S_SCAN_WAIT: begin
                    // regAddr has been stable for SETTLE cycles on the last wait edge.
                    if (cnt == 32'd1) begin
                        dump_data  <= regData;
                        dump_addr  <= regAddr;
                        dump_last  <= (regAddr == LAST_A);
                        dump_valid <= 1'b1;
                        state      <= S_SCAN_OUT;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end

                S_SCAN_OUT: begin
                    if (beat_fire) begin
                        dump_valid <= 1'b0;
                        if (dump_last) begin
                            state     <= S_HALT;
                            halted    <= 1'b1;
                            cmd_ready <= 1'b1;
                            regAddr   <= '0;
                        end else begin
                            state   <= S_SCAN_WAIT;
                            regAddr <= regAddr + ADDR_W'(1);
                            cnt     <= SETTLE_N;
                        end
                    end
                end

                default: begin
                    state      <= S_HALT;
                    cpuEnable  <= 1'b0;
                    halted     <= 1'b1;
                    cmd_ready  <= 1'b1;
                    regAddr    <= '0;
                    dump_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
